// File: rtl/arm_mmio_pkg.sv
// Shared register offsets, FSM state type and STATUS bit layout for the
// memory-mapped UART transmitter.
package arm_mmio_pkg;

  localparam logic [2:0] UART_TXDATA_OFS = 3'h0;
  localparam logic [2:0] UART_STATUS_OFS = 3'h4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int STAT_FULL_BIT   = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_ACTIVE_BIT = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_COUNT_LSB  = 4;
  localparam int STAT_COUNT_MSB  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_MAX);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/arm_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a
// small FIFO, an FSM serialises them LSB first onto a registered tx pin.
module arm_mmio_uart_tx
  import arm_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        sel,
  output logic [31:0] RdData,
  output logic        tx,
  output logic        busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  uart_tx_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             ovf_reg;

  logic [2:0]       ofs;
  logic             push, pop, stat_wr, bit_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      status;
  logic             unused_bits;

  assign unused_bits = ^{WriteData[31:8], DataAdr[1:0]};

  assign sel     = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign ofs     = {DataAdr[2], 2'b00};
  assign push    = MemWrite && sel && (ofs == UART_TXDATA_OFS);
  assign stat_wr = MemWrite && sel && (ofs == UART_STATUS_OFS);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (WriteData[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          // Chain straight into the next start bit so frames run back-to-back.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      // A dropped byte on the same edge as a clear keeps the flag set.
      if (push && fifo_full && !pop)
        ovf_reg <= 1'b1;
      else if (stat_wr && WriteData[STAT_OVF_BIT])
        ovf_reg <= 1'b0;
    end
  end

  always_comb begin
    status                          = '0;
    status[STAT_FULL_BIT]           = fifo_full;
    status[STAT_EMPTY_BIT]          = fifo_empty;
    status[STAT_ACTIVE_BIT]         = (state_reg != IDLE);
    status[STAT_OVF_BIT]            = ovf_reg;
    status[STAT_COUNT_LSB +: CW]    = fifo_count;
  end

  assign RdData = (sel && ofs == UART_STATUS_OFS) ? status : 32'h0;
  assign tx     = tx_reg;
  assign busy   = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_arm_mmio_uart_tx.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared against a frame-timing reference model.
module tb_arm_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        sel;
  logic [31:0] RdData;
  logic        tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  arm_mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .sel       (sel),
    .RdData    (RdData),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a byte queue plus "cycles since frame start".
  logic [7:0] mq[$];
  bit         m_act;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_ovf;

  always @(posedge clk) begin
    bit m_pop, m_sel, wr_d, wr_s;
    int sz;
    if (!reset) begin
      mq.delete();
      m_act = 0;
      m_t   = 0;
      m_ovf = 0;
    end else begin
      m_sel = (DataAdr[31:3] == BASE[31:3]);
      wr_d  = MemWrite && m_sel && !DataAdr[2];
      wr_s  = MemWrite && m_sel && DataAdr[2];
      sz    = mq.size();
      m_pop = 0;
      if (m_act) begin
        m_t = m_t + 1;
        if (m_t == 10 * CPB) begin
          m_act = 0;
          if (sz > 0) m_pop = 1;
        end
      end else if (sz > 0) begin
        m_pop = 1;
      end
      if (m_pop) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t   = 0;
      end
      if (wr_s && WriteData[3]) m_ovf = 0;
      if (wr_d) begin
        if (sz < DEPTH || m_pop) mq.push_back(WriteData[7:0]);
        else m_ovf = 1;
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = 32'h0;
    s[0]   = (mq.size() == DEPTH);
    s[1]   = (mq.size() == 0);
    s[2]   = m_act;
    s[3]   = m_ovf;
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic e_sel;
    if (cmp_en) begin
      e_sel = (DataAdr[31:3] == BASE[31:3]);
      chk("model_tx", {31'b0, tx}, {31'b0, exp_tx()});
      chk("model_busy", {31'b0, busy}, {31'b0, (m_act || mq.size() != 0)});
      chk("model_sel", {31'b0, sel}, {31'b0, e_sel});
      chk("model_rddata", RdData, (e_sel && DataAdr[2]) ? exp_status() : 32'h0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    cyc(1);
    MemWrite  = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    MemWrite = 1'b0;
    DataAdr  = BASE + 32'h4;
    #1;
    v = RdData;
  endtask

  logic [31:0] st;
  int          exp_bits[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  logic [31:0] addr_tab[8] = '{32'h100, 32'h104, 32'h101, 32'h106,
                               32'h108, 32'h0F8, 32'h000, 32'h200};
  bit          tx_dropped;

  initial begin
    reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
    cyc(2);
    rd_status(st);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_status", st, 32'h0000_0002);
    cmp_en = 1;
    reset  = 1'b1;
    cyc(2);

    // Single byte 0x41
    wr(BASE, 32'h41);
    cyc(2);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("single_bit%0d", b), {31'b0, tx}, exp_bits[b]);
      if (b < 9) cyc(4);
    end
    cyc(2);
    chk("single_busy_last", {31'b0, busy}, 32'h1);
    cyc(1);
    chk("single_busy_fall", {31'b0, busy}, 32'h0);
    cyc(3);

    // Back-to-back 0x55, 0xA3
    wr(BASE, 32'h55);
    wr(BASE, 32'hA3);
    cyc(9);
    rd_status(st);
    chk("b2b_status_count1", st, 32'h0000_0014);
    cyc(30);
    chk("b2b_stop_high", {31'b0, tx}, 32'h1);
    cyc(1);
    chk("b2b_second_start", {31'b0, tx}, 32'h0);
    cyc(45);

    // Overflow with six stores
    for (int i = 1; i <= 6; i++) wr(BASE, 32'(i));
    rd_status(st);
    chk("ovf_status_set", st, 32'h0000_004D);
    wr(BASE + 32'h4, 32'h8);
    rd_status(st);
    chk("ovf_status_clear", st, 32'h0000_0045);
    cyc(215);

    // Full FIFO with a store landing on the STOP->START pop edge
    for (int i = 0; i < 5; i++) wr(BASE, 32'h11 + 32'(i));
    cyc(36);
    wr(BASE, 32'h16);
    rd_status(st);
    chk("fullpop_status", st, 32'h0000_0045);
    cyc(210);

    // Reset during DATA bit 3 with two bytes queued
    wr(BASE, 32'h21);
    wr(BASE, 32'h22);
    wr(BASE, 32'h23);
    cyc(16);
    reset = 1'b0;
    cyc(1);
    rd_status(st);
    chk("midreset_tx", {31'b0, tx}, 32'h1);
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    chk("midreset_status", st, 32'h0000_0002);
    reset = 1'b1;
    tx_dropped = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (tx !== 1'b1) tx_dropped = 1;
    end
    chk("no_frame_after_reset", {31'b0, tx_dropped}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) != 0);
      MemWrite  = ($urandom_range(0, 9) == 0);
      DataAdr   = addr_tab[$urandom_range(0, 7)];
      WriteData = $urandom;
      cyc(1);
    end
    reset    = 1'b1;
    MemWrite = 1'b0;
    DataAdr  = 32'h0;
    cyc(250);
    chk("drain_idle", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
